// File: rtl/otter_pkg.sv
// Shared definitions for the OTTER core: opcode encodings, funct3 constants
// and the control-unit state type.
package otter_pkg;

  typedef enum logic [6:0] {
    OpcLoad   = 7'b0000011,
    OpcStore  = 7'b0100011,
    OpcBranch = 7'b1100011,
    OpcJal    = 7'b1101111,
    OpcJalr   = 7'b1100111,
    OpcLui    = 7'b0110111,
    OpcAuipc  = 7'b0010111,
    OpcOp     = 7'b0110011,
    OpcOpImm  = 7'b0010011,
    OpcSystem = 7'b1110011
  } opcode_t;

  localparam logic [2:0] F3_CSRRW = 3'b001;
  localparam logic [2:0] F3_MRET  = 3'b000;

  typedef enum logic [2:0] {
    StInit,
    StFetch,
    StExec,
    StWb,
    StIntr
  } cu_state_t;

endpackage

// File: rtl/otter_cu_fsm.sv
// Multicycle sequencing controller: steps each instruction through fetch,
// execute and optional writeback, takes interrupts at boundaries, counts retirements.
module otter_cu_fsm
  import otter_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INTR,
  input  logic             MIE,
  input  logic [6:0]       CU_OPCODE,
  input  logic [2:0]       FUNC,
  output logic             PC_WRITE,
  output logic             REG_WRITE,
  output logic             MEM_RDEN1,
  output logic             MEM_RDEN2,
  output logic             MEM_WE2,
  output logic             CSR_WE,
  output logic             RST_OUT,
  output logic             INT_TAKEN,
  output logic             MRET_EXEC,
  output logic [CNT_W-1:0] INSTRET
);

  cu_state_t        state_q, state_d;
  logic             int_pend_q, int_pend_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             take_int;
  logic             retire;

  assign take_int = int_pend_q & MIE;

  always_comb begin
    state_d   = state_q;
    PC_WRITE  = 1'b0;
    REG_WRITE = 1'b0;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    CSR_WE    = 1'b0;
    RST_OUT   = 1'b0;
    INT_TAKEN = 1'b0;
    MRET_EXEC = 1'b0;
    unique case (state_q)
      StInit: begin
        RST_OUT = 1'b1;
        state_d = StFetch;
      end
      StFetch: begin
        MEM_RDEN1 = 1'b1;
        state_d   = StExec;
      end
      StExec: begin
        case (CU_OPCODE)
          OpcLoad: MEM_RDEN2 = 1'b1;
          OpcStore: begin
            MEM_WE2  = 1'b1;
            PC_WRITE = 1'b1;
          end
          OpcBranch: PC_WRITE = 1'b1;
          OpcOp, OpcOpImm, OpcLui, OpcAuipc, OpcJal, OpcJalr: begin
            PC_WRITE  = 1'b1;
            REG_WRITE = 1'b1;
          end
          OpcSystem: begin
            PC_WRITE = 1'b1;
            if (FUNC == F3_CSRRW) begin
              CSR_WE    = 1'b1;
              REG_WRITE = 1'b1;
            end else if (FUNC == F3_MRET) begin
              MRET_EXEC = 1'b1;
            end
          end
          // Unknown opcodes retire as a nop so the PC keeps moving.
          default: PC_WRITE = 1'b1;
        endcase
        if (CU_OPCODE == OpcLoad) begin
          state_d = StWb;
        end else if (take_int) begin
          state_d = StIntr;
        end else begin
          state_d = StFetch;
        end
      end
      StWb: begin
        REG_WRITE = 1'b1;
        PC_WRITE  = 1'b1;
        state_d   = take_int ? StIntr : StFetch;
      end
      StIntr: begin
        INT_TAKEN = 1'b1;
        PC_WRITE  = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StInit;
    endcase
  end

  // Interrupt entry writes the PC too but is not a retired instruction.
  assign retire = PC_WRITE & ((state_q == StExec) | (state_q == StWb));

  always_comb begin
    int_pend_d = int_pend_q;
    if (state_q == StIntr) begin
      int_pend_d = 1'b0;
    end else if (INTR) begin
      int_pend_d = 1'b1;
    end
  end

  always_comb begin
    instret_d = instret_q;
    if (retire) begin
      instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StInit;
      int_pend_q <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      int_pend_q <= int_pend_d;
      instret_q  <= instret_d;
    end
  end

  assign INSTRET = instret_q;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Self-checking bench for otter_cu_fsm: per-instruction expected strobe sequences,
// a strobe table, directed corner cases and randomized instruction streams.
module tb_otter_cu_fsm;
  import otter_pkg::*;

  // Strobe order: {pc_wr, reg_wr, rden1, rden2, we2, csr_we, rst_out, int_taken, mret}
  localparam logic [8:0] VInit  = 9'b000000100;
  localparam logic [8:0] VFetch = 9'b001000000;
  localparam logic [8:0] VWb    = 9'b110000000;
  localparam logic [8:0] VIntr  = 9'b100000010;

  typedef struct {
    logic [8:0] v;
    bit         bnd;
    bit         cnt;
    bit         is_int;
  } exp_t;

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f;
    logic [8:0] v;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        intr = 1'b0;
  logic        mie = 1'b0;
  logic [6:0]  opc = 7'd0;
  logic [2:0]  func = 3'd0;
  logic        pc_write, reg_write, mem_rden1, mem_rden2, mem_we2;
  logic        csr_we, rst_out, int_taken, mret_exec;
  logic [31:0] instret;
  logic        s_pc_write, s_reg_write, s_mem_rden1, s_mem_rden2, s_mem_we2;
  logic        s_csr_we, s_rst_out, s_int_taken, s_mret_exec;
  logic [2:0]  s_instret;
  logic [8:0]  out_v, out_s;

  exp_t        exp_q[$];
  bit          pend;
  logic [31:0] retired;
  logic [8:0]  last_v;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl[14];

  always #5 clk = ~clk;

  assign out_v = {pc_write, reg_write, mem_rden1, mem_rden2, mem_we2,
                  csr_we, rst_out, int_taken, mret_exec};
  assign out_s = {s_pc_write, s_reg_write, s_mem_rden1, s_mem_rden2, s_mem_we2,
                  s_csr_we, s_rst_out, s_int_taken, s_mret_exec};

  otter_cu_fsm #(.CNT_W(32)) dut (
    .CLK(clk), .RST(rst), .INTR(intr), .MIE(mie), .CU_OPCODE(opc), .FUNC(func),
    .PC_WRITE(pc_write), .REG_WRITE(reg_write), .MEM_RDEN1(mem_rden1),
    .MEM_RDEN2(mem_rden2), .MEM_WE2(mem_we2), .CSR_WE(csr_we), .RST_OUT(rst_out),
    .INT_TAKEN(int_taken), .MRET_EXEC(mret_exec), .INSTRET(instret)
  );

  // Narrow counter copy so wrap-around happens every eight retirements.
  otter_cu_fsm #(.CNT_W(3)) dut_s (
    .CLK(clk), .RST(rst), .INTR(intr), .MIE(mie), .CU_OPCODE(opc), .FUNC(func),
    .PC_WRITE(s_pc_write), .REG_WRITE(s_reg_write), .MEM_RDEN1(s_mem_rden1),
    .MEM_RDEN2(s_mem_rden2), .MEM_WE2(s_mem_we2), .CSR_WE(s_csr_we), .RST_OUT(s_rst_out),
    .INT_TAKEN(s_int_taken), .MRET_EXEC(s_mret_exec), .INSTRET(s_instret)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [8:0] v, input bit b, input bit c, input bit i);
    exp_t e;
    e.v = v; e.bnd = b; e.cnt = c; e.is_int = i;
    return e;
  endfunction

  function automatic logic [8:0] exec_vec(input logic [6:0] o, input logic [2:0] f);
    if (o == OpcLoad) return 9'b000100000;
    if (o == OpcStore) return 9'b100010000;
    if (o == OpcBranch) return 9'b100000000;
    if (o == OpcOp || o == OpcOpImm || o == OpcLui || o == OpcAuipc ||
        o == OpcJal || o == OpcJalr) return 9'b110000000;
    if (o == OpcSystem && f == 3'b001) return 9'b110001000;
    if (o == OpcSystem && f == 3'b000) return 9'b100000001;
    return 9'b100000000;
  endfunction

  task automatic issue(input logic [6:0] o, input logic [2:0] f);
    opc  = o;
    func = f;
    exp_q.push_back(mk(VFetch, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(exec_vec(o, f), o != OpcLoad, 1'b1, 1'b0));
    if (o == OpcLoad) exp_q.push_back(mk(VWb, 1'b1, 1'b1, 1'b0));
  endtask

  // One clock cycle: called #1 after a rising edge, returns #1 after the next one.
  task automatic cycle(input logic i_intr, input logic i_mie);
    exp_t cur;
    intr = i_intr;
    mie  = i_mie;
    @(negedge clk);
    cur    = exp_q.pop_front();
    last_v = out_v;
    chk("strobes", {23'd0, out_v}, {23'd0, cur.v});
    chk("strobes_small", {23'd0, out_s}, {23'd0, cur.v});
    if (cur.bnd && pend && i_mie) exp_q.push_back(mk(VIntr, 1'b0, 1'b0, 1'b1));
    if (cur.cnt && cur.v[8]) retired = retired + 32'd1;
    if (cur.is_int) pend = 1'b0;
    else if (i_intr) pend = 1'b1;
    @(posedge clk);
    #1;
    chk("instret", instret, retired);
    chk("instret_small", {29'd0, s_instret}, {29'd0, retired[2:0]});
  endtask

  task automatic drain(input logic [3:0] ip, input logic mv, input bit rnd);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 8) begin
      if (rnd) cycle($urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
      else cycle((k < 4) ? ip[k] : 1'b0, mv);
      k++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_bound: got %0d pending cycles, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    intr = 1'b0;
    mie  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", {23'd0, out_v}, {23'd0, VInit});
    chk("rst_instret", instret, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    pend    = 1'b0;
    retired = 32'd0;
    exp_q.push_back(mk(VInit, 1'b0, 1'b0, 1'b0));
    drain(4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    logic [6:0] ro;
    tbl[0]  = '{OpcLoad,   3'b010, 9'b000100000};
    tbl[1]  = '{OpcStore,  3'b010, 9'b100010000};
    tbl[2]  = '{OpcBranch, 3'b001, 9'b100000000};
    tbl[3]  = '{OpcOp,     3'b000, 9'b110000000};
    tbl[4]  = '{OpcOpImm,  3'b111, 9'b110000000};
    tbl[5]  = '{OpcLui,    3'b000, 9'b110000000};
    tbl[6]  = '{OpcAuipc,  3'b000, 9'b110000000};
    tbl[7]  = '{OpcJal,    3'b000, 9'b110000000};
    tbl[8]  = '{OpcJalr,   3'b000, 9'b110000000};
    tbl[9]  = '{OpcSystem, 3'b001, 9'b110001000};
    tbl[10] = '{OpcSystem, 3'b000, 9'b100000001};
    tbl[11] = '{OpcSystem, 3'b010, 9'b100000000};
    tbl[12] = '{7'b0000000, 3'b000, 9'b100000000};
    tbl[13] = '{7'b0001111, 3'b000, 9'b100000000};

    do_reset();

    // OP straight after reset: two cycles, count 0 -> 1.
    issue(OpcOp, 3'b000);
    drain(4'b0000, 1'b1, 1'b0);
    chk("op_exec", {23'd0, last_v}, {23'd0, 9'b110000000});
    chk("op_instret", instret, 32'd1);

    // LOAD: no PC write in execute, writeback retires it.
    issue(OpcLoad, 3'b010);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    chk("load_exec", {23'd0, last_v}, {23'd0, 9'b000100000});
    chk("load_exec_instret", instret, 32'd1);
    cycle(1'b0, 1'b1);
    chk("load_wb", {23'd0, last_v}, {23'd0, VWb});
    chk("load_instret", instret, 32'd2);

    // One-cycle INTR pulse during fetch: entry right after execute, one cycle only.
    issue(OpcOp, 3'b000);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    chk("intr_taken", {23'd0, last_v}, {23'd0, VIntr});
    chk("intr_instret", instret, 32'd3);
    issue(OpcBranch, 3'b000);
    cycle(1'b0, 1'b1);
    chk("intr_one_cycle", {23'd0, last_v}, {23'd0, VFetch});
    drain(4'b0000, 1'b1, 1'b0);

    // Pending interrupt held across ten instructions with MIE=0.
    issue(OpcOp, 3'b000);
    drain(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      issue(OpcOpImm, 3'b000);
      drain(4'b0000, 1'b0, 1'b0);
    end
    chk("mie0_no_entry", {23'd0, last_v}, {23'd0, 9'b110000000});
    issue(OpcOp, 3'b000);
    drain(4'b0000, 1'b1, 1'b0);
    chk("mie1_entry", {23'd0, last_v}, {23'd0, VIntr});

    // INTR arriving in the execute cycle itself is taken one boundary later.
    issue(OpcOp, 3'b000);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    chk("late_intr_not_taken", {31'd0, 1'b0}, {31'd0, exp_q.size() != 0});
    issue(OpcOp, 3'b000);
    drain(4'b0000, 1'b1, 1'b0);
    chk("late_intr_next", {23'd0, last_v}, {23'd0, VIntr});

    // Strobe table.
    for (int i = 0; i < 14; i++) begin
      issue(tbl[i].opc, tbl[i].f);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      chk("table_exec", {23'd0, last_v}, {23'd0, tbl[i].v});
      drain(4'b0000, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of execute.
    issue(OpcStore, 3'b000);
    cycle(1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_strobes", {23'd0, out_v}, {23'd0, VInit});
    chk("async_rst_strobes_small", {23'd0, out_s}, {23'd0, VInit});
    chk("async_rst_instret", instret, 32'd0);
    do_reset();

    // Randomized instruction stream with random INTR/MIE.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) ro = 7'($urandom);
      else ro = tbl[$urandom_range(0, 13)].opc;
      issue(ro, 3'($urandom));
      drain(4'b0000, 1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/otter_cu_fsm.md
# otter_cu_fsm

Multicycle sequencing controller for the OTTER RV32I core. It sits directly upstream of the combinational decoder/branch-condition stage. It steps each instruction through fetch, execute and optional writeback. It produces the register-file, memory, PC and CSR write strobes, and it generates the `INT_TAKEN` pulse that the decoder consumes to select the trap vector. It also latches pending interrupts and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports (one clock; reset is asynchronous and active-high):
- `CLK`  in  1  system clock, rising edge
- `RST`  in  1  asynchronous, active-high reset
- `INTR`  in  1  level-sensitive external interrupt request
- `MIE`  in  1  interrupt enable from CSR `mstatus.MIE`
- `CU_OPCODE`  in  7  `IR[6:0]`
- `FUNC`  in  3  `IR[14:12]`
- `PC_WRITE`  out  1  PC register load enable
- `REG_WRITE`  out  1  register-file write enable
- `MEM_RDEN1`  out  1  instruction memory read
- `MEM_RDEN2`  out  1  data memory read
- `MEM_WE2`  out  1  data memory write
- `CSR_WE`  out  1  CSR write enable
- `RST_OUT`  out  1  reset to PC/register file, high in INIT
- `INT_TAKEN`  out  1  interrupt entry, to decoder and CSR file
- `MRET_EXEC`  out  1  mret in execute
- `INSTRET`  out  `CNT_W`  retired-instruction count

## Operation
- States: ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_INTR.
- `RST` forces ST_INIT asynchronously. It also clears `int_pend` and `INSTRET`.
- Outputs are combinational from the state and, in ST_EXEC only, from `CU_OPCODE`/`FUNC`. Every output not listed below is 0.
- ST_INIT: `RST_OUT`=1. Next state is ST_FETCH.
- ST_FETCH: `MEM_RDEN1`=1. Next state is ST_EXEC.
- ST_EXEC, outputs by opcode:
  - LOAD 0000011: `MEM_RDEN2`=1.
  - STORE 0100011: `MEM_WE2`=1, `PC_WRITE`=1.
  - BRANCH 1100011: `PC_WRITE`=1.
  - OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111: `PC_WRITE`=1, `REG_WRITE`=1.
  - SYSTEM 1110011 with `FUNC`=001 (csrrw): `CSR_WE`=1, `REG_WRITE`=1, `PC_WRITE`=1.
  - SYSTEM 1110011 with `FUNC`=000 (mret): `MRET_EXEC`=1, `PC_WRITE`=1.
  - Any other opcode or SYSTEM `FUNC`: `PC_WRITE`=1 only (treated as nop).
- ST_EXEC next state: LOAD → ST_WB; else (`int_pend` & `MIE`) → ST_INTR; else ST_FETCH.
- ST_WB: `REG_WRITE`=1, `PC_WRITE`=1. Next state: (`int_pend` & `MIE`) → ST_INTR, else ST_FETCH.
- ST_INTR: `INT_TAKEN`=1, `PC_WRITE`=1. Next state is ST_FETCH.
- `int_pend` register:
  - Set at any clock edge where `INTR`=1.
  - Cleared at the edge leaving ST_INTR. Clear wins over set in that cycle.
  - A still-asserted `INTR` re-sets it one cycle later, during ST_FETCH.
  - It is held, not dropped, while `MIE`=0.
- `INSTRET`:
  - Increments by 1 at the edge ending any cycle where `PC_WRITE`=1 in ST_EXEC or ST_WB. ST_INTR does not count.
  - Unsigned modulo 2^`CNT_W`; all-ones wraps to 0.

## Timing
- Reset values: state ST_INIT, `RST_OUT`=1, all other strobes 0, `INSTRET`=0, `int_pend`=0.
- The first ST_FETCH occurs one cycle after `RST` deasserts.
- Latency:
  - Non-load instruction: 2 cycles (FETCH, EXEC).
  - Load: 3 cycles (FETCH, EXEC, WB).
  - Interrupt entry adds 1 cycle after the retiring instruction.
- Interrupts are accepted only at instruction boundaries, never between FETCH and EXEC.
- The `INTR` sampled at the ST_EXEC edge itself is too late for that boundary. It is taken at the next boundary.
- `MIE` is sampled combinationally in the deciding cycle. An mret/csrrw that changes `MIE` takes effect at the following boundary.
- `RST` asserted mid-instruction: outputs return to reset values within the same cycle, with no clock required. The partially executed instruction is abandoned uncounted.

## Structure
- Shared package `otter_pkg`:
  - opcode enum (LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP, OP_IMM, SYSTEM);
  - `FUNC` constants F3_CSRRW=001 and F3_MRET=000;
  - state enum `cu_state_t`.
- Single flat module with no sub-module. The counter and latch are a few lines each.

## Test plan
- Reset release, then OP (0110011): ST_INIT→FETCH→EXEC. In EXEC, `PC_WRITE`=`REG_WRITE`=1. `INSTRET` goes 0→1.
- LOAD: `MEM_RDEN2`=1 in EXEC with `PC_WRITE`=0. Next cycle (WB) has `REG_WRITE`=`PC_WRITE`=1. 3 cycles total, `INSTRET`+1.
- `INTR` pulsed 1 cycle during FETCH with `MIE`=1: after EXEC, ST_INTR with `INT_TAKEN`=1 for exactly 1 cycle. `INSTRET` is unchanged by ST_INTR.
- `INTR` pulsed with `MIE`=0 for 10 instructions, then `MIE`=1: interrupt taken at the next boundary.
- SYSTEM `FUNC`=000: `MRET_EXEC`=1 and `PC_WRITE`=1 in EXEC. SYSTEM `FUNC`=001: `CSR_WE`=1.
- Preload `INSTRET`=0xFFFFFFFF by forced state, retire one instruction → 0x00000000. Assert `RST` mid-EXEC → `RST_OUT`=1 and all strobes 0 with no clock edge.
